// File: rtl/node_integrator.sv
// node_integrator: steps a set of wheel nodes one time step forward.
//
// A step request pulses the force generator, waits (bounded) for its result,
// snapshots the force vectors, then walks the nodes one per cycle applying
//   v' = sat_V(v + (f >>> FORCE_SHIFT) - (v >>> DAMP_SHIFT))
//   p' = sat_P(p + v')
// to both axes in parallel. The position registers are the authoritative node
// state and are fed back to the force generators.
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   load_in, init_nodes  in IDLE: load positions, clear velocities
//   begin_in             step request (IDLE only)
//   force_begin_out      one-cycle start pulse to the force generator
//   force_valid_in       generator result flag (WAIT only)
//   forces               generator force vectors, [axis][node]
//   nodes_out            registered positions, [axis][node]
//   velocities_out       registered velocities, [axis][node]
//   busy_out             high whenever not IDLE
//   result_out           one-cycle pulse when a step completes
//   timeout_out          one-cycle pulse when the generator wait expires

// Per-axis update datapath for a single node (purely combinational).
module node_integrator_axis #(
  parameter int POSITION_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SHIFT   = 2,
  parameter int DAMP_SHIFT    = 3
) (
  input  logic [FORCE_SIZE-1:0]    f_in,
  input  logic [VELOCITY_SIZE-1:0] v_in,
  input  logic [POSITION_SIZE-1:0] p_in,
  output logic [VELOCITY_SIZE-1:0] v_out,
  output logic [POSITION_SIZE-1:0] p_out
);
  localparam int MW = (POSITION_SIZE > FORCE_SIZE)
                    ? ((POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE)
                    : ((FORCE_SIZE > VELOCITY_SIZE) ? FORCE_SIZE : VELOCITY_SIZE);
  // Two guard bits: the sums below never exceed twice the widest operand.
  localparam int W = MW + 2;

  localparam logic signed [W-1:0] VMAX = W'((1 << (VELOCITY_SIZE-1)) - 1);
  localparam logic signed [W-1:0] VMIN = ~VMAX;
  localparam logic signed [W-1:0] PMAX = W'((1 << (POSITION_SIZE-1)) - 1);
  localparam logic signed [W-1:0] PMIN = ~PMAX;

  logic signed [W-1:0] f_e, v_e, p_e, sum_v, v_sat, sum_p;

  always_comb begin
    f_e   = {{(W-FORCE_SIZE){f_in[FORCE_SIZE-1]}}, f_in};
    v_e   = {{(W-VELOCITY_SIZE){v_in[VELOCITY_SIZE-1]}}, v_in};
    p_e   = {{(W-POSITION_SIZE){p_in[POSITION_SIZE-1]}}, p_in};
    sum_v = v_e + (f_e >>> FORCE_SHIFT) - (v_e >>> DAMP_SHIFT);
    if (sum_v > VMAX)      v_sat = VMAX;
    else if (sum_v < VMIN) v_sat = VMIN;
    else                   v_sat = sum_v;
    // Position integrates the already-saturated new velocity.
    sum_p = p_e + v_sat;
    v_out = v_sat[VELOCITY_SIZE-1:0];
    if (sum_p > PMAX)      p_out = PMAX[POSITION_SIZE-1:0];
    else if (sum_p < PMIN) p_out = PMIN[POSITION_SIZE-1:0];
    else                   p_out = sum_p[POSITION_SIZE-1:0];
  end
endmodule

module node_integrator #(
  parameter int NUM_NODES     = 10,
  parameter int POSITION_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SHIFT   = 2,
  parameter int DAMP_SHIFT    = 3,
  parameter int TIMEOUT       = 15
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic load_in,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] init_nodes,
  input  logic begin_in,
  output logic force_begin_out,
  input  logic force_valid_in,
  input  logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]    forces,
  output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_out,
  output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] velocities_out,
  output logic busy_out,
  output logic result_out,
  output logic timeout_out
);
  localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_WAIT, S_CAPTURE, S_UPDATE, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] pos_q, pos_d;
  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_q, vel_d;
  // Snapshot of the generator outputs so later changes on `forces` cannot
  // disturb a step already in progress.
  logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]    frc_q, frc_d;

  logic [1:0][VELOCITY_SIZE-1:0] v_new;
  logic [1:0][POSITION_SIZE-1:0] p_new;

  for (genvar a = 0; a < 2; a++) begin : g_axis
    node_integrator_axis #(
      .POSITION_SIZE(POSITION_SIZE),
      .FORCE_SIZE   (FORCE_SIZE),
      .VELOCITY_SIZE(VELOCITY_SIZE),
      .FORCE_SHIFT  (FORCE_SHIFT),
      .DAMP_SHIFT   (DAMP_SHIFT)
    ) u_axis (
      .f_in (frc_q[a][idx_q]),
      .v_in (vel_q[a][idx_q]),
      .p_in (pos_q[a][idx_q]),
      .v_out(v_new[a]),
      .p_out(p_new[a])
    );
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    pos_d           = pos_q;
    vel_d           = vel_q;
    frc_d           = frc_q;
    force_begin_out = 1'b0;
    result_out      = 1'b0;
    timeout_out     = 1'b0;
    busy_out        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (load_in) begin
          pos_d = init_nodes;
          vel_d = '0;
        end else if (begin_in) begin
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        force_begin_out = 1'b1;
        cnt_d           = '0;
        state_d         = S_WAIT;
      end
      S_WAIT: begin
        if (force_valid_in) begin
          frc_d   = forces;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // This is the TIMEOUT-th WAIT cycle without a result.
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            timeout_out = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_CAPTURE: begin
        idx_d   = '0;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        for (int a = 0; a < 2; a++) begin
          pos_d[a][idx_q] = p_new[a];
          vel_d[a][idx_q] = v_new[a];
        end
        if (idx_q == IW'(NUM_NODES - 1)) state_d = S_DONE;
        else                             idx_d   = idx_q + IW'(1);
      end
      S_DONE: begin
        result_out = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      vel_q   <= '0;
      frc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      vel_q   <= vel_d;
      frc_q   <= frc_d;
    end
  end

  assign nodes_out      = pos_q;
  assign velocities_out = vel_q;
endmodule
